mem_rr_arbiter: RTL and testbench
=================================

# mem_rr_arbiter

Round-robin arbiter that shares the single-port memory controller among NUM_REQ requesters. Accepts per-requester valid/ready transactions, issues one at a time on the controller's valid/ready port with address/data held stable until ready, returns read data to the granted requester, and aborts transactions whose ready does not arrive within the controller's guaranteed window.

## Interface
- NUM_REQ, 4, number of requesters (2..16, need not be a power of two)
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 5, max cycles after first mem_valid cycle for mem_ready

One clock; reset is asynchronous and active-high.
- clk  in  1  clock, all logic on posedge
- reset  in  1  asynchronous, active-high
- req_valid  in  NUM_REQ  per-requester request; held until its req_ready
- req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  packed write data
- req_rw  in  NUM_REQ  1 = write, 0 = read
- req_ready  out  NUM_REQ  one-cycle completion pulse to granted requester
- req_err  out  1  high with req_ready when transaction timed out
- req_rdata  out  DATA_W  read data, valid while req_ready high on a read
- mem_valid  out  1  to controller valid
- mem_address  out  ADDR_W  to controller address
- mem_write_data  out  DATA_W  to controller write_data
- mem_read_write  out  1  to controller read_write
- mem_ready  in  1  from controller ready
- mem_read_data  in  DATA_W  from controller read_data
- grant_id  out  $clog2(NUM_REQ) (min 1)  index of current/last granted requester
- timeout_err  out  1  sticky; set on any timeout, cleared only by reset

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: if any req_valid, pick winner g by round-robin starting at ptr, searching upward with wrap; register g into grant_id, latch req_addr/req_wdata/req_rw of g into mem_* registers, set mem_valid, clear wait counter, go BUSY. No request: stay IDLE.
- BUSY: mem_valid=1; mem_address, mem_write_data, mem_read_write constant. If mem_ready=1: capture mem_read_data into req_rdata when read, go DONE. Else if counter == TIMEOUT: set timeout_err, flag err, go DONE. Else counter++.
- DONE: req_ready[grant_id]=1 for exactly one cycle, req_err = flag; mem_valid=0; ptr ← (grant_id+1) mod NUM_REQ; go IDLE.
- Write completions: req_rdata holds previous value.
- Requests arriving in BUSY/DONE wait; req_valid of a requester sampled only in IDLE.
- Requester must drop or renew req_valid the cycle after its req_ready; arbiter does not re-sample in DONE, so no duplicate issue.
- Reset (any state): all outputs 0, ptr 0, counter 0, state IDLE; in-flight transaction dropped, no req_ready issued.

## Timing
- Request first high in IDLE at cycle t -> mem_valid high from cycle t+1.
- mem_ready sampled high at BUSY cycle t+k (k ≥ 1) -> req_ready pulse at t+k+1, mem_valid low at t+k+1; back-to-back next grant earliest mem_valid at t+k+3.
- mem_ready accepted on any of the first TIMEOUT+1 mem_valid cycles; absent on all -> req_ready+req_err at the following cycle.
- mem_ready while mem_valid low: ignored.
- Address-stability: mem_address/mem_write_data/mem_read_write never change while mem_valid && !mem_ready.
- No combinational path from req_* or mem_ready to any output.

## Structure
- Package mem_arb_pkg: state enum (ARB_IDLE, ARB_BUSY, ARB_DONE), TIMEOUT default, counter-width constant $clog2(TIMEOUT+1).
- Sub-module rr_picker: combinational rotate-priority search (inputs req vector, ptr; outputs any, idx); instantiated once.
- Bench binds the controller's valid/ready, address-stability and read-data-known properties onto the mem_* side.

## Test plan
- Single read from requester 2, addr 0x1000, mem_ready 3 cycles after mem_valid, rdata 0xDEADBEEF -> mem_address 0x1000 stable 3 cycles, req_ready[2] one pulse, req_rdata 0xDEADBEEF, req_err 0.
- All 4 requesters valid continuously after reset -> grant order 0,1,2,3,0; each mem_valid window carries that requester's address.
- Requester 1 writes 0x55AA55AA, ready after 1 cycle -> mem_read_write 1, mem_write_data 0x55AA55AA, req_ready[1] pulse, ptr moves to 2.
- mem_ready never asserted -> after 6 mem_valid cycles, req_ready[g] and req_err pulse, timeout_err stays 1 through subsequent normal transactions.
- reset asserted on second BUSY cycle -> mem_valid, req_ready, grant_id, timeout_err all 0 asynchronously; after release, requester 3 alone -> granted with no stale issue.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory round-robin arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_DONE = 2'd2
    } arb_state_e;

    localparam int ARB_TIMEOUT_DEFAULT = 5;

    // Wait counter must reach TIMEOUT; never narrower than one bit.
    function automatic int cnt_width(input int timeout);
        return ($clog2(timeout + 1) < 1) ? 1 : $clog2(timeout + 1);
    endfunction

    localparam int ARB_CNT_W = cnt_width(ARB_TIMEOUT_DEFAULT);

endpackage

// File: rtl/mem_rr_arbiter_rr_picker.sv
// rtl/mem_rr_arbiter_rr_picker.sv - rotate-priority search starting at ptr
//
// Ports:
//   req_i  requester valid vector
//   ptr_i  highest-priority index for this search
//   any_o  at least one request present
//   idx_o  first requesting index at or above ptr_i, wrapping at N
module rr_picker #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic         any_o,
    output logic [W-1:0] idx_o
);

    logic [W:0] sum;

    // Walk from the farthest candidate back to ptr so the closest match wins.
    always_comb begin
        any_o = 1'b0;
        idx_o = '0;
        sum   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            sum = {1'b0, ptr_i} + (W+1)'(i);
            if (sum >= (W+1)'(N)) begin
                sum = sum - (W+1)'(N);
            end
            if (req_i[sum[W-1:0]]) begin
                any_o = 1'b1;
                idx_o = sum[W-1:0];
            end
        end
    end

endmodule

// File: rtl/mem_rr_arbiter.sv
// rtl/mem_rr_arbiter.sv - round-robin arbiter sharing one memory controller port
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   req_valid/addr/wdata/rw    per-requester transaction, packed by requester index
//   req_ready, req_err         one-cycle completion pulse to the granted requester, timeout flag
//   req_rdata                  read data of the last completed read
//   mem_valid/address/...      controller request, held stable until mem_ready
//   mem_ready, mem_read_data   controller response
//   grant_id                   current/last granted requester
//   timeout_err                sticky timeout indication
module mem_rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = ARB_TIMEOUT_DEFAULT,
    localparam int GID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    input  logic [NUM_REQ-1:0]        req_rw,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      req_err,
    output logic [DATA_W-1:0]         req_rdata,
    output logic                      mem_valid,
    output logic [ADDR_W-1:0]         mem_address,
    output logic [DATA_W-1:0]         mem_write_data,
    output logic                      mem_read_write,
    input  logic                      mem_ready,
    input  logic [DATA_W-1:0]         mem_read_data,
    output logic [GID_W-1:0]          grant_id,
    output logic                      timeout_err
);

    localparam int CNT_W = (TIMEOUT == ARB_TIMEOUT_DEFAULT) ? ARB_CNT_W : cnt_width(TIMEOUT);

    arb_state_e        state_q, state_d;
    logic [GID_W-1:0]  grant_q, grant_d;
    logic [GID_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              terr_q, terr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rw_q, rw_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              pick_any;
    logic [GID_W-1:0]  pick_idx;
    logic [ADDR_W-1:0] addr_arr  [NUM_REQ];
    logic [DATA_W-1:0] wdata_arr [NUM_REQ];
    logic [NUM_REQ-1:0] grant_onehot;

    rr_picker #(
        .N (NUM_REQ),
        .W (GID_W)
    ) u_picker (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .any_o (pick_any),
        .idx_o (pick_idx)
    );

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
            wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            terr_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rw_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            terr_q  <= terr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rw_q    <= rw_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        terr_d  = terr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rw_d    = rw_q;
        rdata_d = rdata_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    grant_d = pick_idx;
                    addr_d  = addr_arr[pick_idx];
                    wdata_d = wdata_arr[pick_idx];
                    rw_d    = req_rw[pick_idx];
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                // Ready wins over timeout when both land on the last allowed cycle.
                if (mem_ready) begin
                    if (!rw_q) begin
                        rdata_d = mem_read_data;
                    end
                    state_d = ARB_DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    terr_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = ARB_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ARB_DONE: begin
                ptr_d   = (grant_q == GID_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // All outputs derive from registers only, so no input reaches an output combinationally.
    assign grant_onehot   = NUM_REQ'(1) << grant_q;
    assign req_ready      = (state_q == ARB_DONE) ? grant_onehot : '0;
    assign req_err        = (state_q == ARB_DONE) && err_q;
    assign req_rdata      = rdata_q;
    assign mem_valid      = (state_q == ARB_BUSY);
    assign mem_address    = addr_q;
    assign mem_write_data = wdata_q;
    assign mem_read_write = rw_q;
    assign grant_id       = grant_q;
    assign timeout_err    = terr_q;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// tb/tb_mem_rr_arbiter.sv - self-checking bench for mem_rr_arbiter
module tb_mem_rr_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 5;
    localparam int GID_W   = 2;

    logic                      clk;
    logic                      reset;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_rw;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      req_err;
    logic [DATA_W-1:0]         req_rdata;
    logic                      mem_valid;
    logic [ADDR_W-1:0]         mem_address;
    logic [DATA_W-1:0]         mem_write_data;
    logic                      mem_read_write;
    logic                      mem_ready;
    logic [DATA_W-1:0]         mem_read_data;
    logic [GID_W-1:0]          grant_id;
    logic                      timeout_err;

    logic [ADDR_W-1:0] addr_r  [NUM_REQ];
    logic [DATA_W-1:0] wdata_r [NUM_REQ];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Transaction-level model: one outstanding transaction described by its cycle window.
    bit                m_txn, m_ended, m_err, m_rw, m_sticky;
    int                m_first, m_last, m_id, m_ptr, m_grant;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata, m_rdata;
    logic [NUM_REQ-1:0] exp_ready;
    logic [NUM_REQ-1:0] dropped;

    mem_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_rw         (req_rw),
        .req_ready      (req_ready),
        .req_err        (req_err),
        .req_rdata      (req_rdata),
        .mem_valid      (mem_valid),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_write (mem_read_write),
        .mem_ready      (mem_ready),
        .mem_read_data  (mem_read_data),
        .grant_id       (grant_id),
        .timeout_err    (timeout_err)
    );

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_addr[i*ADDR_W +: ADDR_W]  = addr_r[i];
            req_wdata[i*DATA_W +: DATA_W] = wdata_r[i];
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    assert property (@(posedge clk) disable iff (reset)
        (mem_valid && !mem_ready) |=> (!mem_valid || ($stable(mem_address) &&
            $stable(mem_write_data) && $stable(mem_read_write))))
        else begin
            errors++;
            $display("FAIL addr_stable: mem_* changed while waiting for ready at cycle %0d", cyc);
        end

    assert property (@(posedge clk) disable iff (reset)
        (mem_valid && mem_ready && !mem_read_write) |-> !$isunknown(mem_read_data))
        else begin
            errors++;
            $display("FAIL rdata_known: mem_read_data unknown at accepted read, cycle %0d", cyc);
        end

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void model_reset();
        m_txn = 0; m_ended = 0; m_err = 0; m_rw = 0; m_sticky = 0;
        m_first = 0; m_last = 0; m_id = 0; m_ptr = 0; m_grant = 0;
        m_addr = '0; m_wdata = '0; m_rdata = '0;
        exp_ready = '0; dropped = '0;
    endfunction

    // Predict the state after the next edge from the inputs currently driven.
    function automatic void model_advance();
        int idx;
        if (m_txn && m_ended) begin
            m_txn = 0;
            m_ptr = (m_id + 1) % NUM_REQ;
        end else if (m_txn) begin
            if (mem_ready) begin
                m_ended = 1;
                m_last  = cyc;
                if (!m_rw) m_rdata = mem_read_data;
            end else if (cyc - m_first == TIMEOUT) begin
                m_ended  = 1;
                m_last   = cyc;
                m_err    = 1;
                m_sticky = 1;
            end
        end else if (req_valid != '0) begin
            idx = -1;
            for (int k = 0; k < NUM_REQ; k++) begin
                if (idx < 0 && req_valid[(m_ptr + k) % NUM_REQ]) idx = (m_ptr + k) % NUM_REQ;
            end
            m_txn   = 1;
            m_ended = 0;
            m_err   = 0;
            m_first = cyc + 1;
            m_id    = idx;
            m_grant = idx;
            m_addr  = addr_r[idx];
            m_wdata = wdata_r[idx];
            m_rw    = req_rw[idx];
        end
    endfunction

    function automatic void compare();
        bit e_valid;
        e_valid   = m_txn && (!m_ended || cyc <= m_last);
        exp_ready = (m_txn && m_ended && cyc == m_last + 1) ? (NUM_REQ'(1) << m_id) : '0;
        chk("mem_valid", mem_valid, e_valid);
        if (e_valid) begin
            chk("mem_address", mem_address, m_addr);
            chk("mem_write_data", mem_write_data, m_wdata);
            chk("mem_read_write", mem_read_write, m_rw);
        end
        chk("req_ready", req_ready, exp_ready);
        chk("req_err", req_err, (exp_ready != '0) && m_err);
        chk("req_rdata", req_rdata, m_rdata);
        chk("grant_id", grant_id, m_grant);
        chk("timeout_err", timeout_err, m_sticky);
    endfunction

    // Called at a falling edge with inputs set; returns at the next falling edge.
    task automatic cycle();
        model_advance();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        compare();
        dropped   = exp_ready;
        req_valid = req_valid & ~exp_ready;
    endtask

    task automatic apply_reset();
        reset     = 1'b1;
        req_valid = '0;
        mem_ready = 1'b0;
        #1;
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_timeout_err", timeout_err, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        compare();
        reset = 1'b0;
    endtask

    // Serve one controller transaction: ready on the lat-th mem_valid cycle (never if lat < 0).
    task automatic do_mem(input int lat, output int nvalid, output int rdy_id, output bit err,
                          output bit stable, output logic [ADDR_W-1:0] a0,
                          output logic [DATA_W-1:0] w0, output logic rw0);
        nvalid = 0; rdy_id = -1; err = 0; stable = 1; a0 = '0; w0 = '0; rw0 = 0;
        for (int t = 0; t < 40 && rdy_id < 0; t++) begin
            mem_ready = 1'b0;
            if (mem_valid) begin
                nvalid++;
                if (nvalid == 1) begin
                    a0 = mem_address; w0 = mem_write_data; rw0 = mem_read_write;
                end else if (mem_address != a0) begin
                    stable = 0;
                end
                if (nvalid == lat) mem_ready = 1'b1;
            end
            cycle();
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i]) begin
                    rdy_id = i;
                    err    = req_err;
                end
            end
        end
        mem_ready = 1'b0;
    endtask

    int                nv, id, prob, seen;
    bit                er, st;
    logic [ADDR_W-1:0] a0;
    logic [DATA_W-1:0] w0;
    logic              rw0;
    int                exp_ord [5] = '{0, 1, 2, 3, 0};

    initial begin
        reset = 1'b1; req_valid = '0; req_rw = '0; mem_ready = 1'b0; mem_read_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            addr_r[i] = '0; wdata_r[i] = '0;
        end
        model_reset();
        @(negedge clk);
        apply_reset();

        // Single read from requester 2 with ready on the third mem_valid cycle.
        addr_r[2] = 32'h1000; req_rw[2] = 1'b0; req_valid[2] = 1'b1;
        mem_read_data = 32'hDEADBEEF;
        do_mem(3, nv, id, er, st, a0, w0, rw0);
        chk("t1_valid_cycles", nv, 3);
        chk("t1_ready_id", id, 2);
        chk("t1_err", er, 0);
        chk("t1_addr", a0, 32'h1000);
        chk("t1_addr_stable", st, 1);
        chk("t1_rdata", req_rdata, 32'hDEADBEEF);

        // All four requesters continuously valid.
        apply_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            addr_r[i] = 32'h2000 + 32'(i * 16); req_rw[i] = 1'b0;
        end
        req_valid = '1;
        for (int k = 0; k < 5; k++) begin
            mem_read_data = $urandom;
            do_mem(1, nv, id, er, st, a0, w0, rw0);
            chk("t2_grant_order", id, exp_ord[k]);
            chk("t2_window_addr", a0, 32'h2000 + 32'(exp_ord[k] * 16));
            if (id >= 0) req_valid[id] = 1'b1;
        end
        req_valid = '0;

        // Write from requester 1, then check the pointer moved past it.
        apply_reset();
        addr_r[1] = 32'h3000; wdata_r[1] = 32'h55AA55AA; req_rw[1] = 1'b1; req_valid[1] = 1'b1;
        do_mem(2, nv, id, er, st, a0, w0, rw0);
        chk("t3_ready_id", id, 1);
        chk("t3_rw", rw0, 1);
        chk("t3_wdata", w0, 32'h55AA55AA);
        chk("t3_valid_cycles", nv, 2);
        chk("t3_rdata_held", req_rdata, 0);
        addr_r[0] = 32'h4000; req_rw[0] = 1'b0; req_valid[0] = 1'b1;
        addr_r[3] = 32'h4030; req_rw[3] = 1'b0; req_valid[3] = 1'b1;
        do_mem(1, nv, id, er, st, a0, w0, rw0);
        chk("t3_ptr_next_grant", id, 3);

        // Timeout on requester 0 (still pending), then a normal transaction.
        do_mem(-1, nv, id, er, st, a0, w0, rw0);
        chk("t4_valid_cycles", nv, TIMEOUT + 1);
        chk("t4_ready_id", id, 0);
        chk("t4_err", er, 1);
        chk("t4_sticky", timeout_err, 1);
        addr_r[2] = 32'h5000; req_rw[2] = 1'b0; req_valid[2] = 1'b1;
        do_mem(2, nv, id, er, st, a0, w0, rw0);
        chk("t4_next_id", id, 2);
        chk("t4_next_err", er, 0);
        chk("t4_sticky_after", timeout_err, 1);

        // Reset in the second BUSY cycle of a grant to requester 1.
        addr_r[1] = 32'h6000; req_rw[1] = 1'b0; req_valid[1] = 1'b1;
        seen = 0;
        for (int t = 0; t < 10 && seen < 2; t++) begin
            cycle();
            if (mem_valid) seen++;
        end
        chk("t5_reached_busy", seen, 2);
        chk("t5_grant_before", grant_id, 1);
        apply_reset();
        addr_r[3] = 32'h7000; req_rw[3] = 1'b0; req_valid[3] = 1'b1;
        do_mem(1, nv, id, er, st, a0, w0, rw0);
        chk("t5_after_reset_id", id, 3);
        chk("t5_after_reset_addr", a0, 32'h7000);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            case ((n / 500) % 4)
                0: prob = 50;
                1: prob = 15;
                2: prob = 3;
                default: prob = 100;
            endcase
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req_valid[i] && !dropped[i] && $urandom_range(3) == 0) begin
                    addr_r[i]    = $urandom;
                    wdata_r[i]   = $urandom;
                    req_rw[i]    = 1'($urandom_range(1));
                    req_valid[i] = 1'b1;
                end
            end
            mem_ready     = ($urandom_range(99) < prob);
            mem_read_data = $urandom;
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
